button_debouncer: RTL and testbench

//  Conditions one raw push-button/switch input for the LED counter stages.

---
 rtl/button_debouncer.sv | 169 ++++++++++++++++
 tb/tb_button_debouncer.sv | 99 +++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchroniser, stability-counter debounce FSM, registered level and one-cycle strobes.
// Define BUTTON_DEBOUNCER_REPEAT_EN to enable the hold-to-repeat strobe on btn_repeat.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int REP_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_repeat
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      REPEAT_DELAY > (2 ** REP_W) || REPEAT_RATE > (2 ** REP_W)) begin : g_bad_params
    $error("button_debouncer: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_HI  = 2'd1,
    PRESSED = 2'd2,
    ARM_LO  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   btn_sync;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (btn_sync) begin
          state_d = ARM_HI;
          cnt_d   = '0;
        end
      end
      ARM_HI: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          rise_d  = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        level_d = 1'b1;
        if (!btn_sync) begin
          state_d = ARM_LO;
          cnt_d   = '0;
        end
      end
      ARM_LO: begin
        if (btn_sync) begin
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          fall_d  = 1'b1;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic             repeat_q, repeat_d;

  // rep_first_q selects the initial hold delay; after the first strobe the shorter rate applies.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    repeat_d    = 1'b0;
    if (state_q == ARM_HI && state_d == PRESSED) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (state_q == PRESSED) begin
      if (rep_cnt_q == (rep_first_q ? DELAY_LAST : RATE_LAST)) begin
        repeat_d    = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end else if (state_q == IDLE) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      repeat_q    <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      repeat_q    <= repeat_d;
    end
  end

  assign btn_repeat = repeat_q;
`else
  assign btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with short debounce/repeat parameters.
// Repeat expectations follow BUTTON_DEBOUNCER_REPEAT_EN when it is defined for the build.
module tb_button_debouncer;

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b1;
  logic btn_level, btn_rise, btn_fall, btn_repeat;

  int total = 0;
  int bad   = 0;

  button_debouncer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(3),
    .REPEAT_DELAY(10), .REPEAT_RATE(3), .REP_W(5)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(btn_level), .btn_rise(btn_rise),
    .btn_fall(btn_fall), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive inputs just after an edge so the next edge samples them; outputs then read 1 time unit after it.
  task automatic tick(input logic r, input logic b);
    reset  = r;
    btn_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int lvl, input int rise, input int fall);
    check({tag, ".level"}, 32'(btn_level), 32'(lvl));
    check({tag, ".rise"},  32'(btn_rise),  32'(rise));
    check({tag, ".fall"},  32'(btn_fall),  32'(fall));
    check({tag, ".excl"},  32'((int'(btn_rise) + int'(btn_fall) + int'(btn_repeat)) <= 1), 32'd1);
  endtask

  initial begin
    // Reset held two edges with the button already down.
    for (int i = 1; i <= 2; i++) begin
      tick(1'b1, 1'b1);
      check_outs($sformatf("rst%0d", i), 0, 0, 0);
      check($sformatf("rst%0d.rep", i), 32'(btn_repeat), 32'd0);
    end

    // Press accepted on 7th edge after release; repeat at +10 then every 3 while held.
    for (int i = 1; i <= 47; i++) begin
      tick(1'b0, 1'b1);
      check_outs($sformatf("press%0d", i), (i >= 7) ? 1 : 0, (i == 7) ? 1 : 0, 0);
      check($sformatf("press%0d.rep", i), 32'(btn_repeat),
            32'(REP_EN && i >= 17 && ((i - 17) % 3) == 0));
    end

    // Release with a 2-cycle glitch back to 1 in the middle of release qualification.
    for (int j = 1; j <= 13; j++) begin
      tick(1'b0, (j == 4 || j == 5) ? 1'b1 : 1'b0);
      check_outs($sformatf("rel%0d", j), (j < 12) ? 1 : 0, 0, (j == 12) ? 1 : 0);
    end

    // Bounce on press: 1 x3, 0 x2, then 1 held.
    for (int j = 1; j <= 13; j++) begin
      tick(1'b0, (j == 4 || j == 5) ? 1'b0 : 1'b1);
      check_outs($sformatf("bnc%0d", j), (j >= 12) ? 1 : 0, (j == 12) ? 1 : 0, 0);
      check($sformatf("bnc%0d.rep", j), 32'(btn_repeat), 32'd0);
    end

    // Reset while pressed: level drops with no fall strobe, then a fresh press qualifies normally.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    for (int i = 1; i <= 2; i++) begin
      tick(1'b1, 1'b1);
      check_outs($sformatf("mrst%0d", i), 0, 0, 0);
      check($sformatf("mrst%0d.rep", i), 32'(btn_repeat), 32'd0);
    end
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b1);
      check_outs($sformatf("repress%0d", i), (i >= 7) ? 1 : 0, (i == 7) ? 1 : 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
